// File: rtl/reg_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : reg_cmd_issuer
// Description : Command front end for the register bank. Register micro-ops
//               (clear / load / decrement / increment with target register,
//               load data and repeat count) are buffered in a small FIFO and
//               issued one per clock as a one-hot register enable plus shared
//               funsel / data buses. Increment and decrement ops keep their
//               enable asserted for a programmed number of cycles.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   1               rising-edge clock
//   reset_n     in   1               asynchronous active-low reset
//   cmd_valid   in   1               command present
//   cmd_ready   out  1               FIFO can accept a command (not full)
//   cmd_funsel  in   2               00 clear, 01 load, 10 decrement, 11 increment
//   cmd_sel     in   clog2(NRegs)    target register index
//   cmd_data    in   NBits           load value
//   cmd_count   in   CntBits         inc/dec repeat count (0 behaves as 1)
//   reg_e       out  NRegs           one-hot register enable (registered)
//   reg_funsel  out  2               funsel to bank (registered)
//   reg_i       out  NBits           data to bank (registered)
//   busy        out  1               FIFO non-empty or a repeat in progress
//   level       out  clog2(Depth+1)  FIFO occupancy
// ============================================================================
module reg_cmd_issuer #(
  parameter int NBits   = 8,
  parameter int NRegs   = 4,
  parameter int Depth   = 4,
  parameter int CntBits = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_funsel,
  input  logic [$clog2(NRegs)-1:0]   cmd_sel,
  input  logic [NBits-1:0]           cmd_data,
  input  logic [CntBits-1:0]         cmd_count,
  output logic [NRegs-1:0]           reg_e,
  output logic [1:0]                 reg_funsel,
  output logic [NBits-1:0]           reg_i,
  output logic                       busy,
  output logic [$clog2(Depth+1)-1:0] level
);

  localparam int SEL_W = $clog2(NRegs);
  localparam int PTR_W = $clog2(Depth);
  localparam int LVL_W = $clog2(Depth+1);
  localparam int ENT_W = 2 + SEL_W + NBits + CntBits;

  localparam logic [LVL_W-1:0]   C_FULL    = LVL_W'(Depth);
  localparam logic [LVL_W-1:0]   C_LVL_ONE = LVL_W'(1);
  localparam logic [PTR_W-1:0]   C_PTR_ONE = PTR_W'(1);
  localparam logic [CntBits-1:0] C_CNT_ONE = CntBits'(1);
  localparam logic [1:0]         C_FS_LOAD = 2'b01;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REPEAT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  // FIFO storage and bookkeeping; an entry is {funsel, sel, data, count}.
  logic [ENT_W-1:0]     r_mem [Depth];
  logic [PTR_W-1:0]     r_wptr;
  logic [PTR_W-1:0]     r_rptr;
  logic [LVL_W-1:0]     r_level;

  logic [CntBits-1:0]   r_rem;
  logic [CntBits-1:0]   w_rem_nxt;
  logic [NRegs-1:0]     r_reg_e;
  logic [NRegs-1:0]     w_reg_e_nxt;
  logic [1:0]           r_reg_funsel;
  logic [1:0]           w_reg_funsel_nxt;
  logic [NBits-1:0]     r_reg_i;
  logic [NBits-1:0]     w_reg_i_nxt;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_ready;
  logic [ENT_W-1:0]     w_head;
  logic [1:0]           w_head_funsel;
  logic [SEL_W-1:0]     w_head_sel;
  logic [NBits-1:0]     w_head_data;
  logic [CntBits-1:0]   w_head_count;
  logic [NRegs-1:0]     w_head_onehot;

  // Ready is a function of occupancy only, so a full FIFO refuses a push
  // even when the head is popped in the same cycle.
  assign w_ready = (r_level != C_FULL);
  assign w_empty = (r_level == '0);
  assign w_push  = cmd_valid && w_ready;

  assign w_head        = r_mem[r_rptr];
  assign w_head_funsel = w_head[ENT_W-1 -: 2];
  assign w_head_sel    = w_head[SEL_W+NBits+CntBits-1 -: SEL_W];
  assign w_head_data   = w_head[NBits+CntBits-1 -: NBits];
  assign w_head_count  = w_head[CntBits-1:0];

  always_comb begin
    w_head_onehot             = '0;
    w_head_onehot[w_head_sel] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_funsel, cmd_sel, cmd_data, cmd_count};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + C_LVL_ONE;
        2'b01:   r_level <= r_level - C_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rem        <= '0;
      r_reg_e      <= '0;
      r_reg_funsel <= 2'b00;
      r_reg_i      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rem        <= w_rem_nxt;
      r_reg_e      <= w_reg_e_nxt;
      r_reg_funsel <= w_reg_funsel_nxt;
      r_reg_i      <= w_reg_i_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM: next state and next registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_rem_nxt        = r_rem;
    w_reg_e_nxt      = r_reg_e;
    w_reg_funsel_nxt = r_reg_funsel;
    w_reg_i_nxt      = r_reg_i;
    w_pop            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop            = 1'b1;
          w_reg_e_nxt      = w_head_onehot;
          w_reg_funsel_nxt = w_head_funsel;
          w_reg_i_nxt      = (w_head_funsel == C_FS_LOAD) ? w_head_data : '0;
          // funsel[1] marks inc/dec; counts of 0 and 1 both mean one cycle.
          if (w_head_funsel[1] && (w_head_count > C_CNT_ONE)) begin
            w_rem_nxt   = w_head_count - C_CNT_ONE;
            w_state_nxt = S_REPEAT;
          end
        end else begin
          // Bus values are left as they were; only the enable drops.
          w_reg_e_nxt = '0;
        end
      end

      S_REPEAT: begin
        // rem counts the enable cycles still to come after the current one.
        w_rem_nxt = r_rem - C_CNT_ONE;
        if (r_rem == C_CNT_ONE) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready  = w_ready;
  assign reg_e      = r_reg_e;
  assign reg_funsel = r_reg_funsel;
  assign reg_i      = r_reg_i;
  assign level      = r_level;
  // The last enable cycle of a repeat is spent back in IDLE, so busy is
  // already low then unless more commands are queued.
  assign busy       = !w_empty || (r_state == S_REPEAT);

endmodule
`default_nettype wire

// File: tb/tb_reg_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_cmd_issuer
// Description : Self-checking bench for reg_cmd_issuer. A queue-based model
//               predicts the outputs every cycle; directed tests add literal
//               expectations and a register-bank model checks end results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_cmd_issuer;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_funsel;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic [3:0] cmd_count;
  logic [3:0] reg_e;
  logic [1:0] reg_funsel;
  logic [7:0] reg_i;
  logic       busy;
  logic [2:0] level;

  reg_cmd_issuer #(
    .NBits   (8),
    .NRegs   (4),
    .Depth   (DEPTH),
    .CntBits (4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_funsel (cmd_funsel),
    .cmd_sel    (cmd_sel),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .reg_e      (reg_e),
    .reg_funsel (reg_funsel),
    .reg_i      (reg_i),
    .busy       (busy),
    .level      (level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit en    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a command queue plus "enable cycles left" for the
  // op currently on the bus.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] fs;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] c;
  } cmd_t;

  cmd_t       m_q[$];
  cmd_t       m_h;
  cmd_t       m_new;
  bit         m_acc;
  int         m_left;
  logic [3:0] m_e;
  logic [1:0] m_fs;
  logic [7:0] m_i;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_left = 0;
      m_e    = 4'b0;
      m_fs   = 2'b00;
      m_i    = 8'h00;
    end else begin
      m_acc = cmd_valid && (m_q.size() < DEPTH);
      m_new = {cmd_funsel, cmd_sel, cmd_data, cmd_count};
      if (m_left > 1) begin
        m_left--;
      end else if (m_q.size() != 0) begin
        m_h    = m_q.pop_front();
        m_e    = 4'b0001 << m_h.sel;
        m_fs   = m_h.fs;
        m_i    = (m_h.fs == 2'b01) ? m_h.d : 8'h00;
        m_left = m_h.fs[1] ? ((m_h.c == 4'd0) ? 1 : int'(m_h.c)) : 1;
      end else begin
        m_e    = 4'b0;
        m_left = 0;
      end
      if (m_acc) m_q.push_back(m_new);
    end
  end

  // Monitors and register-bank model driven from the DUT bus.
  logic [7:0] bank [4];
  logic [2:0] mon_maxlvl;
  bit         mon_nr;
  int         mon_run;
  int         mon_maxrun;

  always @(negedge clock) begin
    if (en) begin
      chk("reg_e",      32'(reg_e),      32'(m_e));
      chk("reg_funsel", 32'(reg_funsel), 32'(m_fs));
      chk("reg_i",      32'(reg_i),      32'(m_i));
      chk("level",      32'(level),      32'(m_q.size()));
      chk("cmd_ready",  32'(cmd_ready),  32'(m_q.size() < DEPTH));
      chk("busy",       32'(busy),       32'((m_q.size() != 0) || (m_left > 1)));
      if (level > mon_maxlvl) mon_maxlvl = level;
      if (!cmd_ready) mon_nr = 1;
      mon_run = (reg_e != 4'b0) ? mon_run + 1 : 0;
      if (mon_run > mon_maxrun) mon_maxrun = mon_run;
      for (int r = 0; r < 4; r++) begin
        if (reg_e[r]) begin
          case (reg_funsel)
            2'b00:   bank[r] = 8'h00;
            2'b01:   bank[r] = reg_i;
            2'b10:   bank[r] = bank[r] - 8'h01;
            default: bank[r] = bank[r] + 8'h01;
          endcase
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] fs, input logic [1:0] sel,
                      input logic [7:0] d, input logic [3:0] c);
    bit ok;
    int n;
    cmd_valid  = 1'b1;
    cmd_funsel = fs;
    cmd_sel    = sel;
    cmd_data   = d;
    cmd_count  = c;
    ok = 0;
    n  = 0;
    while (!ok && n < 200) begin
      ok = cmd_ready;
      step();
      n++;
    end
    chk("push_accepted", 32'(ok), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || reg_e != 4'b0) && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(n < 300), 32'd1);
  endtask

  logic [7:0] exp_reg [4];
  logic [1:0] rfs;
  logic [1:0] rsel;
  logic [7:0] rdat;
  logic [3:0] rcnt;
  int         run;
  int         reps;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cmd_valid  = 1'b0;
    cmd_funsel = 2'b00;
    cmd_sel    = 2'b00;
    cmd_data   = 8'h00;
    cmd_count  = 4'h0;
    mon_maxlvl = 3'd0;
    mon_nr     = 0;
    mon_run    = 0;
    mon_maxrun = 0;
    for (int r = 0; r < 4; r++) bank[r] = 8'h00;
    reset_n = 1'b0;
    step();
    step();
    chk("rst_reg_e",  32'(reg_e),      32'h0);
    chk("rst_funsel", 32'(reg_funsel), 32'h0);
    chk("rst_ready",  32'(cmd_ready),  32'h1);
    en = 1;
    reset_n = 1'b1;
    step();

    // Load into an idle block: one enable cycle, data then holds.
    push(2'b01, 2'd2, 8'hA5, 4'd0);
    chk("t2_not_yet", 32'(reg_e), 32'h0);
    step();
    chk("t2_reg_e",   32'(reg_e),      32'h4);
    chk("t2_funsel",  32'(reg_funsel), 32'h1);
    chk("t2_reg_i",   32'(reg_i),      32'hA5);
    step();
    chk("t2_one_cyc", 32'(reg_e),      32'h0);
    chk("t2_i_hold",  32'(reg_i),      32'hA5);

    // Increment x5 then clear.
    wait_idle();
    push(2'b11, 2'd1, 8'h00, 4'd5);
    push(2'b00, 2'd3, 8'h77, 4'd9);
    run = 0;
    while (reg_e == 4'b0010 && reg_funsel == 2'b11 && run < 40) begin
      run++;
      step();
    end
    chk("t3_inc_cycles", 32'(run),        32'd5);
    chk("t3_clr_e",      32'(reg_e),      32'h8);
    chk("t3_clr_fs",     32'(reg_funsel), 32'h0);
    chk("t3_clr_i",      32'(reg_i),      32'h0);
    wait_idle();
    push(2'b11, 2'd0, 8'h00, 4'd0);
    step();
    chk("t3_cnt0_e",  32'(reg_e), 32'h1);
    step();
    chk("t3_cnt0_one", 32'(reg_e), 32'h0);

    // Long decrement while the FIFO fills and stalls.
    wait_idle();
    mon_maxlvl = 3'd0;
    mon_nr     = 0;
    push(2'b10, 2'd0, 8'h00, 4'd15);
    for (int k = 0; k < 6; k++) push(2'b01, 2'(k), 8'h10 + 8'(k), 4'd0);
    chk("t4_max_level", 32'(mon_maxlvl), 32'd4);
    chk("t4_not_ready", 32'(mon_nr),     32'd1);
    wait_idle();

    // Eight back-to-back loads.
    mon_run    = 0;
    mon_maxrun = 0;
    for (int k = 0; k < 8; k++) push(2'b01, 2'(k), 8'h30 + 8'(k), 4'd0);
    wait_idle();
    chk("t5_run",   32'(mon_maxrun), 32'd8);
    chk("t5_level", 32'(level),      32'd0);
    chk("t5_busy",  32'(busy),       32'd0);

    // Reset in the middle of a repeat with commands queued.
    push(2'b11, 2'd2, 8'h00, 4'd15);
    push(2'b01, 2'd1, 8'h55, 4'd0);
    push(2'b01, 2'd3, 8'h66, 4'd0);
    step();
    reset_n = 1'b0;
    #1;
    chk("t1_reg_e",  32'(reg_e),      32'h0);
    chk("t1_funsel", 32'(reg_funsel), 32'h0);
    chk("t1_reg_i",  32'(reg_i),      32'h0);
    chk("t1_level",  32'(level),      32'h0);
    chk("t1_ready",  32'(cmd_ready),  32'h1);
    chk("t1_busy",   32'(busy),       32'h0);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("t1_discard_e",   32'(reg_e), 32'h0);
    chk("t1_discard_lvl", 32'(level), 32'h0);

    // Register-bank model: a directed prefix, then a random stream.
    for (int r = 0; r < 4; r++) bank[r] = 8'h00;
    push(2'b00, 2'd0, 8'h00, 4'd0);
    push(2'b01, 2'd0, 8'h10, 4'd0);
    push(2'b11, 2'd0, 8'h00, 4'd3);
    push(2'b00, 2'd1, 8'h00, 4'd0);
    push(2'b10, 2'd1, 8'h00, 4'd0);
    wait_idle();
    chk("t6_r0_lit", 32'(bank[0]), 32'h13);
    chk("t6_r1_lit", 32'(bank[1]), 32'hFF);
    exp_reg[0] = 8'h13;
    exp_reg[1] = 8'hFF;
    exp_reg[2] = 8'h00;
    exp_reg[3] = 8'h00;
    for (int k = 0; k < 24; k++) begin
      rfs  = 2'($urandom_range(0, 3));
      rsel = 2'($urandom_range(0, 3));
      rdat = 8'($urandom);
      rcnt = 4'($urandom_range(0, 15));
      reps = (rcnt == 4'd0) ? 1 : int'(rcnt);
      case (rfs)
        2'b00:   exp_reg[rsel] = 8'h00;
        2'b01:   exp_reg[rsel] = rdat;
        2'b10:   exp_reg[rsel] = exp_reg[rsel] - 8'(reps);
        default: exp_reg[rsel] = exp_reg[rsel] + 8'(reps);
      endcase
      push(rfs, rsel, rdat, rcnt);
      if ($urandom_range(0, 3) == 0) step();
    end
    wait_idle();
    step();
    for (int r = 0; r < 4; r++) chk("t6_bank", 32'(bank[r]), 32'(exp_reg[r]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
